// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - next-PC mode encodings for the program-counter sequencer
package pc_seq_pkg;
  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] PC_HOLD   = 3'd0;
  localparam logic [MODE_W-1:0] PC_INC    = 3'd1;
  localparam logic [MODE_W-1:0] PC_BRANCH = 3'd2;
  localparam logic [MODE_W-1:0] PC_JUMP   = 3'd3;
  localparam logic [MODE_W-1:0] PC_CALL   = 3'd4;
  localparam logic [MODE_W-1:0] PC_RET    = 3'd5;
endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address LIFO that drops the oldest entry on push-when-full
module ras_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         top_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_COUNT = DEPTH[PW:0];
  localparam logic [PW-1:0] PTR_ONE    = 1;
  localparam logic [PW:0]   CNT_ONE    = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    sp;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign top_data = mem[sp - PTR_ONE];

  // sp always names the next free slot; once full it has wrapped onto the oldest entry
  always_ff @(posedge CLK) begin
    if (push)
      mem[sp] <= push_data;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sp    <= '0;
      count <= '0;
    end else if (push) begin
      sp <= sp + PTR_ONE;
      if (!full)
        count <= count + CNT_ONE;
    end else if (pop && !empty) begin
      sp    <= sp - PTR_ONE;
      count <= count - CNT_ONE;
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage PC register with internal next-PC mux and call/return stack
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter int               STEP         = 2,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 16'h0000,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       input_PC_PCWrite,
  input  logic [MODE_W-1:0]          input_PC_mode,
  input  logic [WIDTH-1:0]           input_PC_target,
  input  logic [WIDTH-1:0]           input_PC_offset,
  output logic [WIDTH-1:0]           output_PC,
  output logic [WIDTH-1:0]           output_PC_prev,
  output logic [$clog2(RAS_DEPTH):0] output_RAS_count,
  output logic                       output_RAS_overflow,
  output logic                       output_RAS_underflow,
  output logic                       output_mode_err
);
  logic [WIDTH-1:0] pc_q, prev_q, next_pc, link_addr, top_data;
  logic             ras_push, ras_pop, ras_full, ras_empty;
  logic             is_call, is_ret, is_reserved;

  assign link_addr   = pc_q + WIDTH'(STEP);
  assign is_call     = input_PC_PCWrite && (input_PC_mode == PC_CALL);
  assign is_ret      = input_PC_PCWrite && (input_PC_mode == PC_RET);
  assign is_reserved = input_PC_PCWrite && (input_PC_mode > PC_RET);
  assign ras_push    = is_call;
  assign ras_pop     = is_ret && !ras_empty;

  ras_stack #(.WIDTH(WIDTH), .DEPTH(RAS_DEPTH)) u_ras (
    .CLK       (CLK),
    .RST       (RST),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (link_addr),
    .top_data  (top_data),
    .count     (output_RAS_count),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  always_comb begin
    next_pc = pc_q;
    case (input_PC_mode)
      PC_INC:    next_pc = link_addr;
      PC_BRANCH: next_pc = pc_q + input_PC_offset;
      PC_JUMP:   next_pc = input_PC_target;
      PC_CALL:   next_pc = input_PC_target;
      PC_RET:    if (!ras_empty) next_pc = top_data;
      default:   next_pc = pc_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q                 <= RESET_VECTOR;
      prev_q               <= RESET_VECTOR;
      output_RAS_overflow  <= 1'b0;
      output_RAS_underflow <= 1'b0;
      output_mode_err      <= 1'b0;
    end else if (input_PC_PCWrite) begin
      prev_q <= pc_q;
      pc_q   <= next_pc;
      if (is_call && ras_full)
        output_RAS_overflow <= 1'b1;
      if (is_ret && ras_empty)
        output_RAS_underflow <= 1'b1;
      if (is_reserved)
        output_mode_err <= 1'b1;
    end
  end

  assign output_PC      = pc_q;
  assign output_PC_prev = prev_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - table and scoreboard bench for pc_sequencer
module tb_pc_sequencer;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic [15:0] tgt = '0, off = '0;
  logic [15:0] pc, prev;
  logic [2:0]  cnt;
  logic        ovf, unf, err;

  int checks = 0;
  int fails  = 0;

  always #5 CLK = ~CLK;

  pc_sequencer #(.WIDTH(16), .STEP(2), .RESET_VECTOR(16'h0100), .RAS_DEPTH(4)) dut (
    .CLK                  (CLK),
    .RST                  (RST),
    .input_PC_PCWrite     (we),
    .input_PC_mode        (mode),
    .input_PC_target      (tgt),
    .input_PC_offset      (off),
    .output_PC            (pc),
    .output_PC_prev       (prev),
    .output_RAS_count     (cnt),
    .output_RAS_overflow  (ovf),
    .output_RAS_underflow (unf),
    .output_mode_err      (err)
  );

  typedef struct {
    logic        rst, we;
    logic [2:0]  mode;
    logic [15:0] tgt, off, pc, prev;
    logic [2:0]  cnt;
    logic        ovf, unf, err;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[22];

  function automatic vec_t mk(logic r, logic w, logic [2:0] m, logic [15:0] t, logic [15:0] o,
                              logic [15:0] p, logic [15:0] pv, logic [2:0] c,
                              logic ov, logic un, logic er);
    vec_t v;
    v.rst = r; v.we = w; v.mode = m; v.tgt = t; v.off = o;
    v.pc = p; v.prev = pv; v.cnt = c; v.ovf = ov; v.unf = un; v.err = er;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(negedge CLK);
    RST = v.rst; we = v.we; mode = v.mode; tgt = v.tgt; off = v.off;
    sb.push_back(v);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    check("pc",        idx, pc,          e.pc);
    check("prev",      idx, prev,        e.prev);
    check("ras_count", idx, 16'(cnt),    16'(e.cnt));
    check("overflow",  idx, 16'(ovf),    16'(e.ovf));
    check("underflow", idx, 16'(unf),    16'(e.unf));
    check("mode_err",  idx, 16'(err),    16'(e.err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] m_pc, t;
    logic [15:0] m_stk[$];
    logic        m_ovf, m_unf;
    vec_t        v;

    //            rst we mode  tgt      off      pc       prev     cnt ovf unf err
    tbl[0]  = mk(1, 0, 3'd0, 16'h0,   16'h0,   16'h0100, 16'h0100, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 3'd1, 16'h0,   16'h0,   16'h0102, 16'h0100, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 3'd1, 16'h0,   16'h0,   16'h0102, 16'h0100, 0, 0, 0, 0);
    tbl[3]  = mk(0, 1, 3'd1, 16'h0,   16'h0,   16'h0104, 16'h0102, 0, 0, 0, 0);
    tbl[4]  = mk(0, 1, 3'd1, 16'h0,   16'h0,   16'h0106, 16'h0104, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 3'd4, 16'h0AAA, 16'h0,  16'h0106, 16'h0104, 0, 0, 0, 0);
    tbl[6]  = mk(0, 1, 3'd3, 16'h0010, 16'h0,  16'h0010, 16'h0106, 0, 0, 0, 0);
    tbl[7]  = mk(0, 1, 3'd2, 16'h0,   16'hFFF8, 16'h0008, 16'h0010, 0, 0, 0, 0);
    tbl[8]  = mk(0, 1, 3'd3, 16'hFFFE, 16'h0,  16'hFFFE, 16'h0008, 0, 0, 0, 0);
    tbl[9]  = mk(0, 1, 3'd1, 16'h0,   16'h0,   16'h0000, 16'hFFFE, 0, 0, 0, 0);
    tbl[10] = mk(0, 1, 3'd0, 16'h1234, 16'h0,  16'h0000, 16'h0000, 0, 0, 0, 0);
    tbl[11] = mk(0, 1, 3'd3, 16'h0040, 16'h0,  16'h0040, 16'h0000, 0, 0, 0, 0);
    tbl[12] = mk(0, 1, 3'd4, 16'h0200, 16'h0,  16'h0200, 16'h0040, 1, 0, 0, 0);
    tbl[13] = mk(0, 1, 3'd4, 16'h0300, 16'h0,  16'h0300, 16'h0200, 2, 0, 0, 0);
    tbl[14] = mk(0, 1, 3'd5, 16'h0,   16'h0,   16'h0202, 16'h0300, 1, 0, 0, 0);
    tbl[15] = mk(0, 1, 3'd5, 16'h0,   16'h0,   16'h0042, 16'h0202, 0, 0, 0, 0);
    tbl[16] = mk(0, 1, 3'd7, 16'h0900, 16'h0,  16'h0042, 16'h0042, 0, 0, 0, 1);
    tbl[17] = mk(0, 1, 3'd6, 16'h0900, 16'h4,  16'h0042, 16'h0042, 0, 0, 0, 1);
    tbl[18] = mk(0, 1, 3'd4, 16'h0500, 16'h0,  16'h0500, 16'h0042, 1, 0, 0, 1);
    tbl[19] = mk(1, 1, 3'd4, 16'h0700, 16'h0,  16'h0100, 16'h0100, 0, 0, 0, 0);
    tbl[20] = mk(0, 1, 3'd5, 16'h0,   16'h0,   16'h0100, 16'h0100, 0, 0, 1, 0);
    tbl[21] = mk(0, 0, 3'd5, 16'h0,   16'h0,   16'h0100, 16'h0100, 0, 0, 1, 0);

    for (int i = 0; i < 22; i++)
      apply(tbl[i], i);

    // Overflow then underflow against a reference LIFO that drops its oldest entry when full
    apply(mk(1, 0, 3'd0, 16'h0, 16'h0, 16'h0100, 16'h0100, 0, 0, 0, 0), 100);
    m_pc = 16'h0100; m_ovf = 1'b0; m_unf = 1'b0;
    for (int i = 0; i < 5; i++) begin
      t = 16'h1000 + 16'(i * 256);
      if (m_stk.size() == 4) begin
        void'(m_stk.pop_front());
        m_ovf = 1'b1;
      end
      m_stk.push_back(m_pc + 16'd2);
      v = mk(0, 1, 3'd4, t, 16'h0, t, m_pc, 3'(m_stk.size()), m_ovf, m_unf, 0);
      m_pc = t;
      apply(v, 101 + i);
    end
    for (int i = 0; i < 5; i++) begin
      v = mk(0, 1, 3'd5, 16'h0, 16'h0, m_pc, m_pc, 0, m_ovf, 1'b0, 0);
      if (m_stk.size() > 0) begin
        t = m_stk.pop_back();
        v.pc = t;
      end else begin
        m_unf = 1'b1;
      end
      v.prev = m_pc;
      v.cnt  = 3'(m_stk.size());
      v.unf  = m_unf;
      m_pc   = v.pc;
      apply(v, 110 + i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
